// File: rtl/texture_mapper_packer_pkg.sv
// ============================================================================
// Module : texture_mapper_packer_pkg
// Brief  : Shared helpers for the texture-mapper FIFO packer: counter widths,
//          lane slicing and parameter legality checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package texture_mapper_packer_pkg;

    // Index width for a counter of n states; never narrower than one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic bit ratio_ok(input int r);
        return (r >= 2) && ((r & (r - 1)) == 0);
    endfunction

    function automatic bit line_words_ok(input int n);
        return n >= 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/texture_mapper_wrap_counter.sv
// ============================================================================
// Module : texture_mapper_wrap_counter
// Brief  : Modulo-MODULUS up-counter with enable, synchronous reset and a
//          terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module texture_mapper_wrap_counter
    import texture_mapper_packer_pkg::*;
#(
    parameter int MODULUS = 4,
    parameter int CNT_W   = lane_idx_w(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MODULUS - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign count    = r_count;
    assign terminal = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/texture_mapper_fifo_packer.sv
// ============================================================================
// Module : texture_mapper_fifo_packer
// Brief  : Pops RATIO narrow FWFT-FIFO words into one wide valid/ready beat
//          with per-lane keep and end-of-line marker.
//          Optional: TEXTURE_MAPPER_PACKER_STATS_EN adds beat/stall counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module texture_mapper_fifo_packer
    import texture_mapper_packer_pkg::*;
#(
    parameter int    WIDTH      = 32,
    parameter int    RATIO      = 4,
    parameter int    LINE_WORDS = 640,
    parameter string NAME       = ""
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clken,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_read_data,
    output logic                   fifo_read_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_last
`ifdef TEXTURE_MAPPER_PACKER_STATS_EN
    ,
    output logic [31:0]            stat_beats,
    output logic [31:0]            stat_stall_cycles
`endif
);

    localparam int c_LANE_W = lane_idx_w(RATIO);
    localparam int c_WORD_W = lane_idx_w(LINE_WORDS);
    localparam logic [c_WORD_W-1:0] c_WORD_LAST = c_WORD_W'(LINE_WORDS - 1);

    if (!ratio_ok(RATIO) || !line_words_ok(LINE_WORDS)) begin : g_bad_cfg
        $fatal(1, "%s: illegal RATIO=%0d or LINE_WORDS=%0d", NAME, RATIO, LINE_WORDS);
    end

    logic                   r_valid;
    logic                   r_last;
    logic [WIDTH*RATIO-1:0] r_data;
    logic [RATIO-1:0]       r_keep;
    logic [c_LANE_W-1:0]    w_lane_cnt;
    logic [c_WORD_W-1:0]    w_word_cnt;
    logic                   w_lane_tc;
    logic                   w_word_tc;
    logic                   w_pop;
    logic                   w_drain;
    logic                   w_beat_done;
    logic [WIDTH*RATIO-1:0] w_next_data;
    logic [RATIO-1:0]       w_next_keep;

    assign w_pop       = clken & ~reset & ~fifo_empty & (~r_valid | out_ready);
    assign w_drain     = r_valid & out_ready & clken;
    assign w_beat_done = w_lane_tc | w_word_tc;

    // A line end forces the next word back into lane 0.
    texture_mapper_wrap_counter #(.MODULUS(RATIO)) u_lane_cnt (
        .clk      (clk),
        .rst      (reset | (w_pop & w_word_tc)),
        .en       (w_pop),
        .count    (w_lane_cnt),
        .terminal (w_lane_tc)
    );

    texture_mapper_wrap_counter #(.MODULUS(LINE_WORDS)) u_word_cnt (
        .clk      (clk),
        .rst      (reset),
        .en       (w_pop),
        .count    (w_word_cnt),
        .terminal (w_word_tc)
    );

    // A pop while the previous beat drains starts from an empty lane register.
    always_comb begin
        w_next_data = w_drain ? '0 : r_data;
        w_next_keep = w_drain ? '0 : r_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (w_lane_cnt == c_LANE_W'(k)) begin
                w_next_data[lane_lo(k, WIDTH) +: WIDTH] = fifo_read_data;
                w_next_keep[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (w_pop) begin
            r_data  <= w_next_data;
            r_keep  <= w_next_keep;
            r_valid <= w_beat_done;
            r_last  <= w_beat_done & (w_word_cnt == c_WORD_LAST);
        end else if (w_drain) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end
    end

    assign fifo_read_en = w_pop;
    assign out_valid    = r_valid;
    assign out_last     = r_last;
    assign out_data     = r_data;
    assign out_keep     = r_keep;

`ifdef TEXTURE_MAPPER_PACKER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_beats <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_drain && (r_stat_beats != '1)) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (r_valid && !out_ready && clken && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_beats        = r_stat_beats;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: doc/texture_mapper_fifo_packer.md
Name: texture_mapper_fifo_packer

Overview:
Sink-side stage placed directly downstream of a texture-mapper FWFT FIFO. It pops narrow words from the FIFO and packs RATIO consecutive words into one wide beat. Beats leave on a valid/ready stream with per-lane keep and an end-of-line marker. Sustains one FIFO word per cycle when the consumer never stalls.

Parameters:
WIDTH, 32, bits per FIFO word
RATIO, 4, words per output beat; power of two, at least 2
LINE_WORDS, 640, words per texture line; at least 1; marks the last beat of each line
NAME, "", instance label used only in simulation messages

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
clken  input  1  global clock enable; when low, no state changes and no FIFO pop
fifo_empty  input  1  FWFT FIFO empty flag
fifo_read_data  input  WIDTH  FWFT FIFO head word, valid whenever fifo_empty=0
fifo_read_en  output  1  pop strobe to the FIFO (combinational)
out_valid  output  1  wide beat available
out_ready  input  1  consumer accepts the beat
out_data  output  WIDTH*RATIO  packed beat; lane k = bits [k*WIDTH +: WIDTH]; lane 0 = oldest word
out_keep  output  RATIO  lane k holds valid data
out_last  output  1  beat contains word LINE_WORDS-1 of the current line

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_keep=0, out_last=0, lane_cnt=0, word_cnt=0. fifo_read_en=0 while reset=1.
- pop = clken & ~reset & ~fifo_empty & (~out_valid | out_ready). fifo_read_en = pop.
- drain = out_valid & out_ready & clken.
- On pop:
  - fifo_read_data is written into lane lane_cnt and keep[lane_cnt] is set.
  - If the pop coincides with drain, the lane register first clears: keep becomes one-hot at lane 0 and the other lanes go to 0.
- Beat completion on a pop occurs when lane_cnt==RATIO-1 or word_cnt==LINE_WORDS-1. Next cycle: out_valid=1, and out_last=1 only if word_cnt==LINE_WORDS-1. lane_cnt returns to 0.
- Otherwise lane_cnt increments by 1. word_cnt increments and wraps from LINE_WORDS-1 to 0.
- A line end forces a partial beat. Unfilled lanes carry data 0 and keep 0. The next line always starts in lane 0.
- Drain without pop: out_valid=0, out_keep=0, out_data=0, out_last=0.
- While out_valid=1 and out_ready=0: out_data, out_keep and out_last are held stable, and there is no pop.
- Latency: the beat is valid on the cycle after the final word is popped. No bubble when out_ready stays high.
- clken=0: all registers hold, fifo_read_en=0, and drain does not occur even if out_ready=1.
- Reset mid-beat discards any partially packed words. FIFO contents are the FIFO's own concern.
- Simulation only: error and $finish if RATIO is not a power of two or LINE_WORDS<1.

Optional Feature:
TEXTURE_MAPPER_PACKER_STATS_EN:
- Defined: adds outputs stat_beats[31:0] (count of drains) and stat_stall_cycles[31:0] (count of cycles with out_valid & ~out_ready & clken).
- Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: these ports and the counters do not exist.

Decomposition:
- Shared package texture_mapper_packer_pkg holds:
  - the clog2-based lane index width constant function
  - the lane slice helper
  - the RATIO/LINE_WORDS legality checks
- One sub-module: texture_mapper_wrap_counter (parameterised modulus, enable, synchronous reset, terminal-count output). Instantiated twice, for lane_cnt (modulus RATIO) and word_cnt (modulus LINE_WORDS).

Test Plan:
1. RATIO=4, LINE_WORDS=8, FIFO always non-empty, out_ready=1, words 1..8 -> two beats on consecutive groups, data {4,3,2,1} then {8,7,6,5}, keep 4'hF both, out_last only on the second, fifo_read_en high every cycle.
2. LINE_WORDS=6, words 1..6 -> beat {4,3,2,1} keep F last 0, then {0,0,6,5} keep 4'h3 last 1; word 7 lands in lane 0 of the next beat.
3. Backpressure: out_ready=0 for 5 cycles after the first beat completes -> out_data stable, fifo_read_en=0, no word lost; in STATS_EN build stat_stall_cycles=5.
4. Empty gaps: fifo_empty toggles every other cycle -> identical beats to scenario 1, just spaced out; no pop while fifo_empty=1.
5. clken=0 for 3 cycles mid-beat with out_ready=1 -> no state change and no drain; packing resumes exactly where it stopped.
6. Reset asserted after 2 of 4 words -> next cycle outputs all zero; the following 4 words form a full beat starting at lane 0 with word_cnt restarted.
